// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked execute stage for R-type vector instructions.
// Single-cycle functions come from the combinational ALU below. When
// ALU_EXEC_ITER_DIV_EN is defined, VDIV/VMOD instead run through a 64-step
// lane-serial restoring divider; otherwise they use the ALU's combinational divide.
// Bit 0 of every [0:63] bus is the MSB.

module ALU (
    input  logic [0:63] a_i,
    input  logic [0:63] b_i,
    input  logic [0:5]  rIns_i,
    input  logic [0:1]  ww_i,
    output logic [0:63] result_o
);

    // Lane-wise add/sub/div/mod; lanes never carry or borrow into each other
    function automatic logic [63:0] laneArith(input logic [63:0] a, input logic [63:0] b,
                                              input logic [1:0] ww, input logic [5:0] fn);
        logic [63:0] r, mask, la, lb, lr;
        int w;
        r = '0;
        w = 8 << ww;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        for (int k = 0; k < 8; k++) begin
            la = '0;
            lb = '0;
            lr = '0;
            if (k * w < 64) begin
                la = (a >> (k * w)) & mask;
                lb = (b >> (k * w)) & mask;
                case (fn)
                    6'b000110: lr = la + lb;
                    6'b000111: lr = la - lb;
                    6'b001110: lr = (lb == '0) ? mask : la / lb;
                    6'b001111: lr = (lb == '0) ? la : la % lb;
                    default:   lr = '0;
                endcase
                r = r | ((lr & mask) << (k * w));
            end
        end
        return r;
    endfunction

    logic [63:0] aVal, bVal, res;
    logic [5:0]  fn;
    logic [1:0]  wVal;

    // Function decode; codes not listed here produce zero
    always_comb begin
        aVal = a_i;
        bVal = b_i;
        fn   = rIns_i;
        wVal = ww_i;
        case (fn)
            6'b000001: res = aVal & bVal;
            6'b000010: res = aVal | bVal;
            6'b000011: res = aVal ^ bVal;
            6'b000100: res = ~aVal;
            6'b000101: res = aVal;
            6'b000110, 6'b000111,
            6'b001110, 6'b001111: res = laneArith(aVal, bVal, wVal, fn);
            default:   res = '0;
        endcase
        result_o = res;
    end

endmodule

module alu_exec_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:63] rA_64bit_val,
    input  logic [0:63] rB_64bit_val,
    input  logic [0:5]  R_ins,
    input  logic [0:5]  Op_code,
    input  logic [0:1]  WW,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:63] ALU_out,
    output logic        busy
);

    localparam logic [5:0] R_TYPE  = 6'b101010;
    localparam logic [5:0] FN_VMOD = 6'b001111;

`ifdef ALU_EXEC_ITER_DIV_EN
    localparam logic [5:0] FN_VDIV = 6'b001110;
    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

    state_t      state_q;
    logic        inReady_q, outValid_q;
    logic [0:63] aluOut_q;
    logic [0:63] aluResult, acceptResult;
    logic        isRType;

    ALU u_alu (
        .a_i     (rA_64bit_val),
        .b_i     (rB_64bit_val),
        .rIns_i  (R_ins),
        .ww_i    (WW),
        .result_o(aluResult)
    );

    assign isRType      = (Op_code == R_TYPE);
    assign acceptResult = isRType ? aluResult : '0;
    assign in_ready     = inReady_q;
    assign out_valid    = outValid_q;
    assign ALU_out      = aluOut_q;

`ifdef ALU_EXEC_ITER_DIV_EN
    logic [0:63]  opA_q, opB_q, res_q, res_d;
    logic         isMod_q, busy_q, isDivOp, qBit, laneEnd;
    logic [1:0]   ww_q;
    logic [5:0]   iter_q;
    logic [63:0]  rem_q, rem_d, laneDiv;
    logic [64:0]  remShift, remSub, divExt;
    int           laneW, it;

    assign isDivOp = isRType && ((R_ins == FN_VDIV) || (R_ins == FN_VMOD));
    assign busy    = busy_q;

    // One restoring-divide step: dividend bit iter_q of the latched operand,
    // divisor taken from the lane that bit belongs to
    always_comb begin
        laneW = 8 << ww_q;
        it    = int'(iter_q);
        case (ww_q)
            2'b00:   begin laneDiv = {56'b0, opB_q[{iter_q[5:3], 3'b000} +: 8]};  laneEnd = &iter_q[2:0]; end
            2'b01:   begin laneDiv = {48'b0, opB_q[{iter_q[5:4], 4'b0000} +: 16]}; laneEnd = &iter_q[3:0]; end
            2'b10:   begin laneDiv = {32'b0, opB_q[{iter_q[5], 5'b00000} +: 32]};  laneEnd = &iter_q[4:0]; end
            default: begin laneDiv = opB_q;                                        laneEnd = &iter_q;     end
        endcase
        remShift = {rem_q, opA_q[iter_q]};
        divExt   = {1'b0, laneDiv};
        qBit     = (remShift >= divExt);
        remSub   = qBit ? (remShift - divExt) : remShift;
        rem_d    = laneEnd ? '0 : remSub[63:0];
        res_d    = res_q;
        if (!isMod_q) begin
            res_d[iter_q] = qBit;
        end else if (laneEnd) begin
            for (int j = 0; j < 64; j++) begin
                if ((j <= it) && (j > it - laneW)) begin
                    res_d[j] = remSub[7'(it - j)];
                end
            end
        end
    end
`else
    assign busy = 1'b0;
`endif

    // Handshake FSM with registered status outputs and result register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            aluOut_q   <= '0;
`ifdef ALU_EXEC_ITER_DIV_EN
            busy_q     <= 1'b0;
            iter_q     <= '0;
            rem_q      <= '0;
            res_q      <= '0;
            opA_q      <= '0;
            opB_q      <= '0;
            isMod_q    <= 1'b0;
            ww_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        inReady_q <= 1'b0;
`ifdef ALU_EXEC_ITER_DIV_EN
                        opA_q   <= rA_64bit_val;
                        opB_q   <= rB_64bit_val;
                        isMod_q <= (R_ins == FN_VMOD);
                        ww_q    <= WW;
                        iter_q  <= '0;
                        rem_q   <= '0;
                        res_q   <= '0;
                        if (isDivOp) begin
                            state_q <= DIV;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q    <= DONE;
                            outValid_q <= 1'b1;
                            aluOut_q   <= acceptResult;
                        end
`else
                        state_q    <= DONE;
                        outValid_q <= 1'b1;
                        aluOut_q   <= acceptResult;
`endif
                    end
                end
`ifdef ALU_EXEC_ITER_DIV_EN
                DIV: begin
                    iter_q <= iter_q + 6'd1;
                    rem_q  <= rem_d;
                    res_q  <= res_d;
                    if (iter_q == 6'd63) begin
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        outValid_q <= 1'b1;
                        aluOut_q   <= res_d;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state_q    <= IDLE;
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: directed vector table, backpressure and
// reset-mid-divide sequences, then random operations checked against a
// lane-by-lane arithmetic reference model.

module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, busy;
    logic [0:63] rA_64bit_val, rB_64bit_val, ALU_out;
    logic [0:5]  R_ins, Op_code;
    logic [0:1]  WW;

    int vectors = 0;
    int miscompares = 0;

`ifdef ALU_EXEC_ITER_DIV_EN
    localparam int DIV_LAT = 64;
`else
    localparam int DIV_LAT = 0;
`endif

    localparam logic [5:0] RT = 6'b101010;

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic [5:0]  fn;
        logic [5:0]  op;
        logic [1:0]  ww;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[10];

    alu_exec_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .rA_64bit_val(rA_64bit_val),
        .rB_64bit_val(rB_64bit_val),
        .R_ins       (R_ins),
        .Op_code     (Op_code),
        .WW          (WW),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ALU_out     (ALU_out),
        .busy        (busy)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Watchdog so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no summary, expected one");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: every lane extracted bit by bit, evaluated as an unsigned w-bit number
    function automatic logic [63:0] refModel(input logic [63:0] a, input logic [63:0] b,
                                             input logic [5:0] fn, input logic [5:0] op,
                                             input logic [1:0] ww);
        logic [63:0] res;
        logic [64:0] la, lb, lr;
        int w, n;
        res = '0;
        if (op != RT) return res;
        w = 8 << ww;
        n = 64 / w;
        for (int k = 0; k < n; k++) begin
            la = '0;
            lb = '0;
            for (int bi = 0; bi < w; bi++) begin
                la[bi] = a[k * w + bi];
                lb[bi] = b[k * w + bi];
            end
            case (fn)
                6'd1:    lr = la & lb;
                6'd2:    lr = la | lb;
                6'd3:    lr = la ^ lb;
                6'd4:    lr = ~la;
                6'd5:    lr = la;
                6'd6:    lr = la + lb;
                6'd7:    lr = la - lb;
                6'd14:   lr = (lb == 0) ? ((65'd1 << w) - 65'd1) : la / lb;
                6'd15:   lr = (lb == 0) ? la : la % lb;
                default: lr = '0;
            endcase
            for (int bi = 0; bi < w; bi++) res[k * w + bi] = lr[bi];
        end
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Issue one op through the handshake and check latency, result and release
    task automatic applyStimulus(input string name, input logic [63:0] a, input logic [63:0] b,
                                 input logic [5:0] fn, input logic [5:0] op, input logic [1:0] ww,
                                 input logic [63:0] exp, input logic holdReady);
        int n, guard, expLat;
        expLat = ((op == RT) && ((fn == 6'd14) || (fn == 6'd15))) ? DIV_LAT : 0;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checkOutput({name, " in_ready timeout"}, 64'(in_ready), 64'd1);
            return;
        end
        rA_64bit_val = a;
        rB_64bit_val = b;
        R_ins        = fn;
        Op_code      = op;
        WW           = ww;
        in_valid     = 1'b1;
        out_ready    = holdReady;
        @(posedge clk);
        @(negedge clk);
        in_valid     = 1'b0;
        rA_64bit_val = {$urandom, $urandom};
        rB_64bit_val = {$urandom, $urandom};
        R_ins        = 6'($urandom);
        WW           = 2'($urandom);
        if (expLat > 0) checkOutput({name, " busy during divide"}, 64'(busy), 64'd1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " out_valid"}, 64'(out_valid), 64'd1);
        checkOutput({name, " latency"}, 64'(n), 64'(expLat));
        checkOutput({name, " result"}, ALU_out, exp);
        checkOutput({name, " busy after"}, 64'(busy), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput({name, " out_valid drop"}, 64'(out_valid), 64'd0);
        checkOutput({name, " in_ready back"}, 64'(in_ready), 64'd1);
        out_ready = 1'b0;
    endtask

    // Main sequence
    initial begin
        logic [63:0] a, b, exp;
        logic [5:0]  fn, op;
        logic [1:0]  ww;
        logic        sawValid;
        logic [5:0]  fnList[9];

        fnList = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd14, 6'd15};

        vecs[0] = '{"VAND",       64'd15, 64'd14, 6'd1, RT, 2'b10, 64'h0000_0000_0000_000E};
        vecs[1] = '{"VOR",        64'd15, 64'd14, 6'd2, RT, 2'b10, 64'h0000_0000_0000_000F};
        vecs[2] = '{"VDIV w8",    64'hFF00FF00_FF00FF00, 64'h11221122_44444444, 6'd14, RT, 2'b00, 64'h0F000F00_03000300};
        vecs[3] = '{"VMOD w64",   64'd102, 64'd10, 6'd15, RT, 2'b11, 64'd2};
        vecs[4] = '{"VDIV by 0",  64'h00000064_00000007, 64'h00000000_00000002, 6'd14, RT, 2'b10, 64'hFFFFFFFF_00000003};
        vecs[5] = '{"VMOD by 0",  64'h00000064_00000007, 64'h00000000_00000002, 6'd15, RT, 2'b10, 64'h00000064_00000001};
        vecs[6] = '{"non R-type", 64'd15, 64'd14, 6'd1, 6'b000000, 2'b10, 64'd0};
        vecs[7] = '{"VADD w8",    64'h00FF7F80_01020304, 64'h00010180_01020304, 6'd6, RT, 2'b00, 64'h00008000_02040608};
        vecs[8] = '{"VSUB w16",   64'h00000005_0010FFFF, 64'h00010003_00100001, 6'd7, RT, 2'b01, 64'hFFFF0002_0000FFFE};
        vecs[9] = '{"VXOR w64",   64'hF0F0F0F0_F0F0F0F0, 64'hFF00FF00_FF00FF00, 6'd3, RT, 2'b11, 64'h0FF00FF0_0FF00FF0};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        rA_64bit_val = '0;
        rB_64bit_val = '0;
        R_ins = '0;
        Op_code = '0;
        WW = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset ALU_out", ALU_out, 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].fn, vecs[i].op, vecs[i].ww, vecs[i].exp, 1'b0);
        end

        // out_ready held high before the result appears has no effect
        applyStimulus("VMOD early ready", 64'd102, 64'd10, 6'd15, RT, 2'b11, 64'd2, 1'b1);

        // Backpressure: result held, a pulsed request is ignored
        @(negedge clk);
        rA_64bit_val = 64'd15;
        rB_64bit_val = 64'd14;
        R_ins = 6'd1;
        Op_code = RT;
        WW = 2'b10;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("bp out_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp hold ALU_out", ALU_out, 64'h0E);
            checkOutput("bp hold in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp hold out_valid", 64'(out_valid), 64'd1);
            if (i == 2) begin
                R_ins = 6'd2;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("bp release in_ready", 64'(in_ready), 64'd1);
        checkOutput("bp release out_valid", 64'(out_valid), 64'd0);
        checkOutput("bp ALU_out kept", ALU_out, 64'h0E);
        sawValid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("bp pulse not accepted", 64'(sawValid), 64'd0);

        // Reset at iteration 30 of a divide
        @(negedge clk);
        rA_64bit_val = 64'hFF00FF00_FF00FF00;
        rB_64bit_val = 64'h11221122_44444444;
        R_ins = 6'd14;
        Op_code = RT;
        WW = 2'b00;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (29) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rst mid out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst mid in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst mid ALU_out", ALU_out, 64'd0);
        checkOutput("rst mid busy", 64'(busy), 64'd0);
        sawValid = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("rst discarded op", 64'(sawValid), 64'd0);
        applyStimulus("VMOD after reset", 64'd102, 64'd10, 6'd15, RT, 2'b11, 64'd2, 1'b0);

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            fn = fnList[$urandom_range(0, 8)];
            ww = 2'($urandom);
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : RT;
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(1, 62);
            if ($urandom_range(0, 3) == 0) b = b & 64'hFF00FFFF_0000FF00;
            exp = refModel(a, b, fn, op, ww);
            applyStimulus("random", a, b, fn, op, ww, exp, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Handshaked execute-stage responder that accepts one R-type vector instruction at a time, computes it, and holds the 64-bit result until the consumer takes it. Sits between the decode/issue stage and writeback. It instantiates the existing combinational `ALU` for all single-cycle functions. VDIV and VMOD are routed to an internal iterative restoring divider so the long divide path leaves the critical path.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  request presented
- `in_ready`  out  1  unit can accept a request
- `rA_64bit_val`  in  [0:63]  operand A; bit 0 is the MSB
- `rB_64bit_val`  in  [0:63]  operand B
- `R_ins`  in  [0:5]  function code
- `Op_code`  in  [0:5]  opcode; 101010 means R-type
- `WW`  in  [0:1]  lane width: 00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = 64-bit
- `out_valid`  out  1  result held
- `out_ready`  in  1  consumer takes the result
- `ALU_out`  out  [0:63]  result
- `busy`  out  1  high when the state is DIV

## Operation
- States: IDLE, DIV, DONE.
- Reset values: state = IDLE, `in_ready` = 1, `out_valid` = 0, `ALU_out` = 0, `busy` = 0, iteration counter = 0.
- `in_ready` = (state == IDLE). `out_valid` = (state == DONE).
- Accept occurs on an edge with `in_valid && in_ready`. All operands, `R_ins`, `Op_code` and `WW` are latched at accept. Later input changes are ignored.
- IDLE → DONE on accept when the op is not VDIV (001110) or VMOD (001111). `ALU_out` is loaded with the registered output of the combinational `ALU`, computed from the latched inputs.
- An `Op_code` other than 101010 still completes the handshake, with `ALU_out` = 0.
- IDLE → DIV on accept of VDIV or VMOD.
- Divider operation:
  - The operand is split into 64/w lanes. Lane 0 is bits [0:w-1].
  - Lanes are processed serially from lane 0 upward, w iterations per lane, so there are always exactly 64 iterations.
  - Each iteration shifts the partial remainder (w+1 bits) left and brings in the next dividend bit, MSB first.
  - If partial remainder ≥ divisor: subtract and set the quotient bit to 1. Otherwise set the quotient bit to 0.
  - At the end of each lane, the lane's quotient (VDIV) or remainder (VMOD) is written into that lane of the result register, and the partial remainder is cleared.
- All values are unsigned. There is no carry or borrow between lanes.
- Divide by zero, per lane: quotient = all ones, remainder = dividend lane. This is the natural restoring result, and there is no flag.
- DIV → DONE on iteration 63; the result register drives `ALU_out`.
- DONE → IDLE on `out_ready`. `ALU_out` keeps its last value while in IDLE.
- `in_valid` is ignored outside IDLE, so throughput is at most one op per 2 cycles.
- Reset low on any edge overrides everything:
  - return to reset values;
  - any in-flight op is discarded and never produces `out_valid`.

## Timing
- Single-cycle ops: accept at edge E0 → `out_valid` = 1 after E0.
- VDIV/VMOD:
  - accept at E0 → iterations on E1..E64;
  - `out_valid` = 1 after E64, for a latency of 64 cycles independent of `WW` and operand values.
- `ALU_out` is stable for every cycle that `out_valid` = 1.
- `out_valid` falls after the first edge with `out_ready` = 1. `in_ready` rises in the same cycle.
- `out_ready` asserted before `out_valid` has no effect.

## Configuration
- `ALU_EXEC_ITER_DIV_EN` defined:
  - the iterative divider and the DIV state are compiled in;
  - VDIV/VMOD take 64 cycles as above.
- Not defined:
  - the divider and the DIV state are absent, and `busy` is tied to 0;
  - VDIV/VMOD take the combinational `ALU` result like every other function, with 1-cycle latency;
  - results are identical either way, including divide by zero.

## Test plan
- VAND: `R_ins` = 000001, rA = 64'd15, rB = 64'd14, `WW` = 10 → `ALU_out` = 64'h0000000E with `out_valid` 1 cycle after accept; VOR with the same operands → 64'h0000000F.
- VDIV, `WW` = 00: rA = FF00FF00_FF00FF00, rB = 11221122_44444444 → `ALU_out` = 0F000F00_03000300, `out_valid` exactly 64 cycles after accept, `busy` high during iterations.
- VMOD, `WW` = 11: 64'd102 mod 64'd10 → 64'd2.
- Divide by zero, `WW` = 10: rA = 00000064_00000007, rB = 00000000_00000002:
  - VDIV → FFFFFFFF_00000003;
  - VMOD → 00000064_00000001.
- Backpressure: hold `out_ready` = 0 for 5 cycles after `out_valid` rises → `ALU_out` unchanged, `in_ready` = 0, a pulsed `in_valid` is not accepted; raise `out_ready` → `in_ready` = 1 the next cycle.
- Reset mid-divide: drive `rst_n` low at iteration 30 → after that edge `out_valid` = 0, `in_ready` = 1, `ALU_out` = 0, `busy` = 0; a following VMOD of 102 by 10 returns 2.
